uart_rx_frame: RTL

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_rx_frame.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with a mid-bit sampling FSM feeding a small receive FIFO.
// Bad stop bits and FIFO overruns are reported as single-cycle pulses.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       async_rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [15:0]     cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            bit_tick, cnt_clr, shift_en, push, ferr_set;

    logic [FIFO_DEPTH-1:0][7:0] mem_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            full, pop, push_ok, overrun_d;

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) sync_q <= 2'b11;
        else              sync_q <= {sync_q[0], rx_i};
    end
    assign rx_s     = sync_q[1];
    assign bit_tick = (cnt_q == BIT_LAST);

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rx_s) state_d = START;
            START:     if (cnt_q == HALF_LAST) state_d = rx_s ? IDLE : DATA;
            DATA:      if (bit_tick && bit_idx_q == 3'd7) state_d = STOP;
            STOP:      if (bit_tick) state_d = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state_q != IDLE);
        shift_en = (state_q == DATA) && bit_tick;
        push     = (state_q == STOP) && bit_tick && rx_s;
        ferr_set = (state_q == STOP) && bit_tick && !rx_s;
        cnt_clr  = (state_q == IDLE) || (state_q == WAIT_HIGH)
                || ((state_q == START) && (cnt_q == HALF_LAST))
                || (((state_q == DATA) || (state_q == STOP)) && bit_tick);
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            cnt_q <= cnt_clr ? 16'd0 : cnt_q + 16'd1;
            if (state_q == IDLE) bit_idx_q <= '0;
            else if (shift_en)   bit_idx_q <= bit_idx_q + 3'd1;
            // LSB arrives first, so shifting right leaves bit 0 in place after 8 samples
            if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
        end
    end

    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign valid_o   = (count_q != '0);
    assign pop       = valid_o && ready_i;
    assign push_ok   = push && (!full || pop);
    assign overrun_d = push && full && !pop;
    assign data_o    = valid_o ? mem_q[rd_ptr_q] : 8'h00;

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            frame_err_o <= ferr_set;
            overrun_o   <= overrun_d;
        end
    end
endmodule
